// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program counter sequencer with branch shadow slot and return-address stack
module pc_seq #(
    parameter int unsigned     PC_W      = 16,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall,
    input  logic            BrValid,
    input  logic [2:0]      BrMode,
    input  logic [PC_W-1:0] BrTarget,
    input  logic            Zero,
    input  logic            Neg,
    output logic [PC_W-1:0] Pc,
    output logic [1:0]      PcCtrl,
    output logic            Flush,
    output logic            RasEmpty,
    output logic            RasFull,
    output logic            RasErr
);

    localparam int unsigned OCC_W = $clog2(RAS_DEPTH + 1);

    localparam logic [1:0] CTRL_HOLD = 2'd0;
    localparam logic [1:0] CTRL_SEQ  = 2'd1;
    localparam logic [1:0] CTRL_RET  = 2'd2;
    localparam logic [1:0] CTRL_JUMP = 2'd3;

    localparam logic [2:0] MODE_CALL = 3'b110;
    localparam logic [2:0] MODE_RET  = 3'b111;

    typedef enum logic {
        RUN,
        SHADOW
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_nxt;
    logic [PC_W-1:0] ras [RAS_DEPTH];
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_nxt;
    logic [1:0]      ctrl_nxt;
    logic            flush_nxt;
    logic            err_nxt;
    logic            push;
    logic            pop;
    logic            taken;

    // Sequential address wraps naturally at 2^PC_W; it is also the return address pushed on a call.
    assign pc_inc   = Pc + PC_W'(1);
    assign RasEmpty = (occ == '0);
    assign RasFull  = (occ == OCC_W'(RAS_DEPTH));

    // Decode whether the requested mode would be taken given the current flags and stack.
    always_comb begin
        taken = 1'b0;
        case (BrMode)
            3'b000:  taken = 1'b1;
            3'b001:  taken = !Zero;
            3'b010:  taken = Zero;
            3'b011:  taken = 1'b0;
            3'b100:  taken = Neg;
            3'b101:  taken = !Neg && !Zero;
            3'b110:  taken = 1'b1;
            3'b111:  taken = !RasEmpty;
            default: taken = 1'b0;
        endcase
    end

    // Next-state, next-pc and stack control; stall holds everything and reports a hold decision.
    always_comb begin
        state_nxt = state;
        pc_nxt    = Pc;
        ctrl_nxt  = CTRL_HOLD;
        flush_nxt = 1'b0;
        occ_nxt   = occ;
        err_nxt   = RasErr;
        push      = 1'b0;
        pop       = 1'b0;
        if (!Stall) begin
            pc_nxt   = pc_inc;
            ctrl_nxt = CTRL_SEQ;
            case (state)
                RUN: begin
                    if (BrValid) begin
                        if (taken) begin
                            state_nxt = SHADOW;
                            flush_nxt = 1'b1;
                            if (BrMode == MODE_RET) begin
                                pop      = 1'b1;
                                pc_nxt   = ras[0];
                                ctrl_nxt = CTRL_RET;
                                occ_nxt  = occ - OCC_W'(1);
                            end else begin
                                pc_nxt   = BrTarget;
                                ctrl_nxt = CTRL_JUMP;
                                if (BrMode == MODE_CALL) begin
                                    push = 1'b1;
                                    // A full stack drops its oldest entry, so occupancy saturates.
                                    if (RasFull) begin
                                        err_nxt = 1'b1;
                                    end else begin
                                        occ_nxt = occ + OCC_W'(1);
                                    end
                                end
                            end
                        end else if (BrMode == MODE_RET) begin
                            // A return is only ever not taken because the stack is empty.
                            err_nxt = 1'b1;
                        end
                    end
                end
                SHADOW: begin
                    // Wrong-path slot: any request here is discarded.
                    state_nxt = RUN;
                end
            endcase
        end
    end

    // Architectural registers with synchronous reset overriding stall and requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            Pc     <= RESET_PC;
            PcCtrl <= CTRL_HOLD;
            Flush  <= 1'b0;
            occ    <= '0;
            RasErr <= 1'b0;
        end else begin
            state  <= state_nxt;
            Pc     <= pc_nxt;
            PcCtrl <= ctrl_nxt;
            Flush  <= flush_nxt;
            occ    <= occ_nxt;
            RasErr <= err_nxt;
        end
    end

    // Shift-register stack: entry 0 is the top, the deepest entry falls off on a push.
    always_ff @(posedge clk) begin
        if (push) begin
            ras[0] <= pc_inc;
            for (int i = 1; i < int'(RAS_DEPTH); i++) begin
                ras[i] <= ras[i-1];
            end
        end else if (pop) begin
            for (int i = 0; i < int'(RAS_DEPTH) - 1; i++) begin
                ras[i] <= ras[i+1];
            end
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - self-checking bench for pc_seq
module tb_pc_seq;

    logic        clk;
    logic        rst;
    logic        Stall;
    logic        BrValid;
    logic [2:0]  BrMode;
    logic [15:0] BrTarget;
    logic        Zero;
    logic        Neg;
    logic [15:0] Pc;
    logic [1:0]  PcCtrl;
    logic        Flush;
    logic        RasEmpty;
    logic        RasFull;
    logic        RasErr;

    pc_seq #(.PC_W(16), .RAS_DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk      (clk),
        .rst      (rst),
        .Stall    (Stall),
        .BrValid  (BrValid),
        .BrMode   (BrMode),
        .BrTarget (BrTarget),
        .Zero     (Zero),
        .Neg      (Neg),
        .Pc       (Pc),
        .PcCtrl   (PcCtrl),
        .Flush    (Flush),
        .RasEmpty (RasEmpty),
        .RasFull  (RasFull),
        .RasErr   (RasErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [1:0]  ctrl;
        logic        fl;
        logic        emp;
        logic        full;
        logic        err;
    } exp_t;

    typedef struct {
        logic        r;
        logic        s;
        logic        v;
        logic [2:0]  m;
        logic [15:0] t;
        logic        z;
        logic        n;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic prev_flush = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] pc, input logic [1:0] ctrl, input logic fl,
                                input logic emp, input logic full, input logic err);
        exp_t e;
        e.pc = pc; e.ctrl = ctrl; e.fl = fl; e.emp = emp; e.full = full; e.err = err;
        return e;
    endfunction

    task automatic add(input logic r, input logic s, input logic v, input logic [2:0] m,
                       input logic [15:0] t, input logic z, input logic n, input exp_t e);
        vec_t x;
        x.r = r; x.s = s; x.v = v; x.m = m; x.t = t; x.z = z; x.n = n; x.e = e;
        vecs.push_back(x);
    endtask

    // Drive one cycle of stimulus and queue what the outputs must be after the next edge.
    task automatic step(input logic r, input logic s, input logic v, input logic [2:0] m,
                        input logic [15:0] t, input logic z, input logic n, input exp_t e);
        rst = r; Stall = s; BrValid = v; BrMode = m; BrTarget = t; Zero = z; Neg = n;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare registered outputs shortly after every rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc", 32'(Pc), 32'(e.pc));
            chk("pcctrl", 32'(PcCtrl), 32'(e.ctrl));
            chk("flush", 32'(Flush), 32'(e.fl));
            chk("ras_empty", 32'(RasEmpty), 32'(e.emp));
            chk("ras_full", 32'(RasFull), 32'(e.full));
            chk("ras_err", 32'(RasErr), 32'(e.err));
            chk("flush_twice", 32'(prev_flush & Flush), 32'd0);
            prev_flush = Flush;
        end
    end

    logic [15:0] ret_addr [5];
    logic [15:0] cur;
    logic [15:0] tgt;

    initial begin
        // reset and idle counting
        add(1,0,0,3'b000,16'h0000,0,0, mk(16'h0000,0,0,1,0,0));
        add(0,0,0,3'b000,16'h0000,0,0, mk(16'h0001,1,0,1,0,0));
        add(0,0,0,3'b000,16'h0000,0,0, mk(16'h0002,1,0,1,0,0));
        add(0,0,0,3'b000,16'h0000,0,0, mk(16'h0003,1,0,1,0,0));
        add(0,0,0,3'b000,16'h0000,0,0, mk(16'h0004,1,0,1,0,0));
        add(0,0,0,3'b000,16'h0000,0,0, mk(16'h0005,1,0,1,0,0));
        // conditional taken, then shadow slot ignores a request
        add(0,0,1,3'b010,16'h0040,1,0, mk(16'h0040,3,1,1,0,0));
        add(0,0,1,3'b000,16'h0099,0,0, mk(16'h0041,1,0,1,0,0));
        // not-taken conditions
        add(0,0,1,3'b001,16'h0099,1,0, mk(16'h0042,1,0,1,0,0));
        add(0,0,1,3'b011,16'h0099,0,0, mk(16'h0043,1,0,1,0,0));
        add(0,0,1,3'b101,16'h0099,1,0, mk(16'h0044,1,0,1,0,0));
        add(0,0,1,3'b100,16'h0099,0,0, mk(16'h0045,1,0,1,0,0));
        add(0,0,1,3'b100,16'h000F,0,1, mk(16'h000F,3,1,1,0,0));
        add(0,0,0,3'b000,16'h0000,0,0, mk(16'h0010,1,0,1,0,0));
        // call from 0x10, two cycles, return, empty return
        add(0,0,1,3'b110,16'h0080,0,0, mk(16'h0080,3,1,0,0,0));
        add(0,0,0,3'b000,16'h0000,0,0, mk(16'h0081,1,0,0,0,0));
        add(0,0,0,3'b000,16'h0000,0,0, mk(16'h0082,1,0,0,0,0));
        add(0,0,1,3'b111,16'h0000,0,0, mk(16'h0011,2,1,1,0,0));
        add(0,0,1,3'b111,16'h0000,0,0, mk(16'h0012,1,0,1,0,0));
        add(0,0,1,3'b111,16'h0000,0,0, mk(16'h0013,1,0,1,0,1));
        add(0,0,1,3'b101,16'h0200,0,0, mk(16'h0200,3,1,1,0,1));
        add(0,0,1,3'b001,16'h0300,0,0, mk(16'h0201,1,0,1,0,1));
        add(0,0,1,3'b001,16'h0300,0,0, mk(16'h0300,3,1,1,0,1));
        add(0,0,0,3'b000,16'h0000,0,0, mk(16'h0301,1,0,1,0,1));
        // stall for three cycles with a pending request
        add(0,1,1,3'b000,16'h0500,0,0, mk(16'h0301,0,0,1,0,1));
        add(0,1,1,3'b000,16'h0500,0,0, mk(16'h0301,0,0,1,0,1));
        add(0,1,1,3'b000,16'h0500,0,0, mk(16'h0301,0,0,1,0,1));
        add(0,0,1,3'b000,16'h0500,0,0, mk(16'h0500,3,1,1,0,1));
        add(0,1,1,3'b000,16'h0077,0,0, mk(16'h0500,0,0,1,0,1));
        add(0,0,1,3'b000,16'h0077,0,0, mk(16'h0501,1,0,1,0,1));
        // reset mid-shadow, then wrap
        add(0,0,1,3'b000,16'hFFFE,0,0, mk(16'hFFFE,3,1,1,0,1));
        add(1,0,1,3'b000,16'h1234,0,0, mk(16'h0000,0,0,1,0,0));
        add(0,0,1,3'b000,16'hFFFF,0,0, mk(16'hFFFF,3,1,1,0,0));
        add(0,0,0,3'b000,16'h0000,0,0, mk(16'h0000,1,0,1,0,0));
        // call at 0xFFFF pushes a wrapped return address
        add(0,0,1,3'b000,16'hFFFE,0,0, mk(16'hFFFE,3,1,1,0,0));
        add(0,0,0,3'b000,16'h0000,0,0, mk(16'hFFFF,1,0,1,0,0));
        add(0,0,1,3'b110,16'h0020,0,0, mk(16'h0020,3,1,0,0,0));
        add(0,0,0,3'b000,16'h0000,0,0, mk(16'h0021,1,0,0,0,0));
        add(0,0,1,3'b111,16'h0000,0,0, mk(16'h0000,2,1,1,0,0));
        add(0,0,0,3'b000,16'h0000,0,0, mk(16'h0001,1,0,1,0,0));
        // reset beats stall, and clears a non-empty stack
        add(1,1,1,3'b000,16'h0055,0,0, mk(16'h0000,0,0,1,0,0));
        add(0,0,1,3'b110,16'h0030,0,0, mk(16'h0030,3,1,0,0,0));
        add(1,0,0,3'b000,16'h0000,0,0, mk(16'h0000,0,0,1,0,0));
        add(0,0,1,3'b111,16'h0000,0,0, mk(16'h0001,1,0,1,0,1));

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].s, vecs[i].v, vecs[i].m, vecs[i].t, vecs[i].z, vecs[i].n, vecs[i].e);
        end

        // five nested calls into a four-deep stack, then five returns
        step(1,0,0,3'b000,16'h0000,0,0, mk(16'h0000,0,0,1,0,0));
        cur = 16'h0000;
        for (int k = 0; k < 5; k++) begin
            ret_addr[k] = cur + 16'h0001;
            tgt = 16'((k + 1) << 8);
            step(0,0,1,3'b110,tgt,0,0, mk(tgt,3,1,0,(k >= 3),(k == 4)));
            step(0,0,0,3'b000,16'h0000,0,0, mk(tgt + 16'h0001,1,0,0,(k >= 3),(k == 4)));
            cur = tgt + 16'h0001;
        end
        for (int j = 0; j < 4; j++) begin
            step(0,0,1,3'b111,16'h0000,0,0, mk(ret_addr[4-j],2,1,(j == 3),0,1));
            step(0,0,0,3'b000,16'h0000,0,0, mk(ret_addr[4-j] + 16'h0001,1,0,(j == 3),0,1));
            cur = ret_addr[4-j] + 16'h0001;
        end
        step(0,0,1,3'b111,16'h0000,0,0, mk(cur + 16'h0001,1,0,1,0,1));

        rst = 1'b0; Stall = 1'b0; BrValid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
